// File: rtl/filter_gen_pkg.sv
// Shared types and constants for the filter_gen enrollment stage.
package filter_gen_pkg;

    localparam int unsigned KEY_W = 128;
    localparam int unsigned IDX_W = 7;

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS_DEF = 16'hB400;

    typedef enum logic [2:0] {IDLE, LOAD, FLIP, OUT, DONE} fsm_t;

endpackage

// File: rtl/popcount128.sv
// Combinational population count of a 128-bit word.
module popcount128
    import filter_gen_pkg::*;
(
    input  logic [KEY_W-1:0] din,
    output logic [7:0]       cnt
);

    always_comb begin
        cnt = '0;
        for (int unsigned i = 0; i < KEY_W; i++) begin
            cnt = cnt + 8'(din[i]);
        end
    end

endmodule

// File: rtl/filter_gen.sv
// Builds filter rows F[i] = Pr with exactly H[i] LFSR-chosen bits flipped.
// Optional self-check output verr is enabled by FILTER_GEN_VERIFY_EN.
module filter_gen
    import filter_gen_pkg::*;
#(
    parameter int unsigned       LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400,
    parameter int unsigned       NROWS     = 128
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [KEY_W-1:0] Pr,
    output logic [IDX_W-1:0] h_idx,
    input  logic [IDX_W-1:0] h_val,
    output logic             f_valid,
    input  logic             f_ready,
    output logic [KEY_W-1:0] f_row,
    output logic [IDX_W-1:0] f_idx,
    output logic             busy,
    output logic             done
`ifdef FILTER_GEN_VERIFY_EN
    ,
    output logic             verr
`endif
);

    localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(NROWS - 1);

    fsm_t              state;
    logic [KEY_W-1:0]  pr_q;
    logic [KEY_W-1:0]  work;
    logic [IDX_W-1:0]  tgt;
    logic [IDX_W-1:0]  flips;
    logic [LFSR_W-1:0] lfsr;

    logic [LFSR_W-1:0] lfsr_next;
    logic [IDX_W-1:0]  pos;
    logic [IDX_W-1:0]  flips_inc;
    logic [KEY_W-1:0]  work_flip;
    logic              unflipped;

    always_comb begin
        lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ LFSR_TAPS) : (lfsr >> 1);
        pos       = lfsr[IDX_W-1:0];
        flips_inc = flips + 1'b1;
        work_flip = work ^ (KEY_W'(1) << pos);
        unflipped = (work[pos] == pr_q[pos]);
    end

`ifdef FILTER_GEN_VERIFY_EN
    logic [7:0] dist;

    popcount128 u_popcount (
        .din (work ^ pr_q),
        .cnt (dist)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pr_q    <= '0;
            work    <= '0;
            tgt     <= '0;
            flips   <= '0;
            lfsr    <= LFSR_SEED;
            h_idx   <= '0;
            f_valid <= 1'b0;
            f_row   <= '0;
            f_idx   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef FILTER_GEN_VERIFY_EN
            verr    <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pr_q  <= Pr;
                        h_idx <= '0;
                        lfsr  <= LFSR_SEED;
                        busy  <= 1'b1;
                        state <= LOAD;
`ifdef FILTER_GEN_VERIFY_EN
                        verr  <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    tgt   <= h_val;
                    work  <= pr_q;
                    flips <= '0;
                    if (h_val == '0) begin
                        f_valid <= 1'b1;
                        f_row   <= pr_q;
                        f_idx   <= h_idx;
                        state   <= OUT;
                    end else begin
                        state <= FLIP;
                    end
                end
                FLIP: begin
                    // The LFSR steps on skip cycles too, so row timing depends only on the sequence.
                    lfsr <= lfsr_next;
                    if (unflipped) begin
                        work  <= work_flip;
                        flips <= flips_inc;
                        if (flips_inc == tgt) begin
                            f_valid <= 1'b1;
                            f_row   <= work_flip;
                            f_idx   <= h_idx;
                            state   <= OUT;
                        end
                    end
                end
                OUT: begin
                    if (f_ready) begin
                        f_valid <= 1'b0;
`ifdef FILTER_GEN_VERIFY_EN
                        if (dist != {1'b0, tgt}) verr <= 1'b1;
`endif
                        if (h_idx == LAST_ROW) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            h_idx <= h_idx + 1'b1;
                            state <= LOAD;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_filter_gen.sv
// Self-checking bench for filter_gen against a behavioural row model.
module tb_filter_gen;
    import filter_gen_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [127:0] Pr;
    logic [6:0]   h_idx;
    logic [6:0]   h_val;
    logic         f_valid;
    logic         f_ready;
    logic [127:0] f_row;
    logic [6:0]   f_idx;
    logic         busy;
    logic         done;
`ifdef FILTER_GEN_VERIFY_EN
    logic         verr;
`endif

    logic [6:0]   h_tab  [128];
    logic [127:0] exp_f  [128];
    logic [127:0] got_f  [128];
    logic [127:0] run1_f [128];
    logic [127:0] pr_run;
    logic [127:0] pr1;
    logic [6:0]   h1 [128];

    int unsigned n_pass = 0;
    int unsigned n_fail = 0;
    int unsigned n_total = 0;

    filter_gen #(
        .LFSR_W    (16),
        .LFSR_SEED (16'hACE1),
        .LFSR_TAPS (16'hB400),
        .NROWS     (128)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .Pr      (Pr),
        .h_idx   (h_idx),
        .h_val   (h_val),
        .f_valid (f_valid),
        .f_ready (f_ready),
        .f_row   (f_row),
        .f_idx   (f_idx),
        .busy    (busy),
        .done    (done)
`ifdef FILTER_GEN_VERIFY_EN
        ,
        .verr    (verr)
`endif
    );

    always #5 clk = ~clk;

    assign h_val = h_tab[h_idx];

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: walk the LFSR sequence from the seed, flipping each new position until H[r] distinct bits differ.
    task automatic build_model(input logic [127:0] pr);
        logic [15:0]  l;
        logic [127:0] mask;
        logic [6:0]   p;
        int           cnt;
        l = 16'hACE1;
        for (int r = 0; r < 128; r++) begin
            mask = '0;
            cnt  = 0;
            while (cnt < int'(h_tab[r])) begin
                p = l[6:0];
                if (!mask[p]) begin
                    mask[p] = 1'b1;
                    cnt++;
                end
                l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
            end
            exp_f[r] = pr ^ mask;
        end
    endtask

    task automatic do_start(input logic [127:0] pr);
        @(negedge clk);
        Pr     = pr;
        pr_run = pr;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_f_valid"}, f_valid, 0);
        check({tag, "_f_row"}, f_row, 0);
        check({tag, "_f_idx"}, f_idx, 0);
        check({tag, "_h_idx"}, h_idx, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    // Consumes rows starting from a LOAD-cycle negedge; optional back-pressure, stray start, or reset abort.
    task automatic run_rows(input int bp_row, input int abort_row, input int ign_row,
                            input bit gap_check, input bit dist_check);
        int cyc;
        bit stable;
        for (int r = 0; r < 128; r++) begin
            if (r == abort_row) begin
                @(negedge clk);
                rst_n = 1'b0;
                #1;
                check_idle_outputs("abort");
                return;
            end
            if (r == ign_row) begin
                @(negedge clk);
                start = 1'b1;
                Pr    = ~Pr;
                @(negedge clk);
                start = 1'b0;
            end
            if (r == bp_row) f_ready = 1'b0;
            cyc = 0;
            while (!f_valid && cyc < 70000) begin
                @(negedge clk);
                cyc++;
            end
            if (!f_valid) begin
                check("row_timeout", 0, 1);
                return;
            end
            if (gap_check) check("row_gap", cyc, 1);
            check("f_idx", f_idx, r);
            check("f_row", f_row, exp_f[r]);
            check("busy_run", busy, 1);
            if (dist_check) check("distance", $countones(f_row ^ pr_run), h_tab[r]);
            got_f[r] = f_row;
            if (r == bp_row) begin
                stable = 1'b1;
                repeat (20) begin
                    @(negedge clk);
                    if (!f_valid || f_row !== exp_f[r] || f_idx !== 7'(r)) stable = 1'b0;
                end
                check("bp_stable", stable, 1);
                f_ready = 1'b1;
            end
            @(negedge clk);
            check("f_valid_drop", f_valid, 0);
        end
        check("done_pulse", done, 1);
        check("busy_done", busy, 0);
        @(negedge clk);
        check("done_single", done, 0);
        check("busy_after", busy, 0);
`ifdef FILTER_GEN_VERIFY_EN
        check("verr", verr, 0);
`endif
    endtask

    initial begin
        int diff;
        rst_n   = 1'b0;
        start   = 1'b0;
        f_ready = 1'b1;
        Pr      = '0;
        pr_run  = '0;
        for (int i = 0; i < 128; i++) h_tab[i] = '0;

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check("idle_busy", busy, 0);
            check("idle_valid", f_valid, 0);
        end
        check_idle_outputs("idle");

        // All-zero targets: every row equals Pr, two cycles apart.
        build_model({64{2'b01}});
        do_start({64{2'b01}});
        run_rows(-1, -1, -1, 1'b1, 1'b1);

        // Exact distances, then a repeat with back-pressure on row 5.
        pr1 = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 128; i++) begin
            h_tab[i] = (i % 2) ? 7'd70 : 7'd58;
            h1[i]    = h_tab[i];
        end
        build_model(pr1);
        do_start(pr1);
        run_rows(-1, -1, -1, 1'b0, 1'b1);
        for (int i = 0; i < 128; i++) run1_f[i] = got_f[i];
        do_start(pr1);
        run_rows(5, -1, -1, 1'b0, 1'b1);
        diff = 0;
        for (int i = 0; i < 128; i++) if (got_f[i] !== run1_f[i]) diff++;
        check("repeat_identical", diff, 0);

        // Maximum target on row 0 with a stray start and Pr change during FLIP.
        for (int i = 0; i < 128; i++) h_tab[i] = 7'($urandom_range(0, 12));
        h_tab[0] = 7'd127;
        pr_run = {$urandom, $urandom, $urandom, $urandom};
        build_model(pr_run);
        do_start(pr_run);
        run_rows(-1, -1, 0, 1'b0, 1'b1);

        // Reset during row 40 FLIP, then restart and compare with the first exact-distance run.
        for (int i = 0; i < 128; i++) h_tab[i] = h1[i];
        build_model(pr1);
        do_start(pr1);
        run_rows(-1, 40, -1, 1'b0, 1'b1);
        repeat (3) begin
            @(negedge clk);
            check("rst_no_done", done, 0);
        end
        rst_n = 1'b1;
        do_start(pr1);
        run_rows(-1, -1, -1, 1'b0, 1'b1);
        diff = 0;
        for (int i = 0; i < 128; i++) if (got_f[i] !== run1_f[i]) diff++;
        check("restart_identical", diff, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/filter_gen.md
Name: filter_gen

Overview:
- Enrollment-side stage that builds the filter matrix F consumed by the MAP stage.
- Sits between the HD transform, which supplies the per-row target distances H[i], and MAP.
- For each row i, produces F[i] by flipping exactly H[i] distinct bit positions of the PUF response Pr, so that HD(F[i], Pr) = H[i].
- Bit positions are chosen by an internal LFSR. Rows are emitted one per valid/ready handshake.

Parameters:
- LFSR_W, 16, LFSR width in bits (min 8).
- LFSR_SEED, 16'hACE1, value loaded into the LFSR at reset and on every accepted start; must be nonzero.
- LFSR_TAPS, 16'hB400, Galois feedback mask (maximal length for 16 bits).
- NROWS, 128, rows per run; row index width is 7 bits.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when the block is idle.
- Pr  in  128  PUF response; sampled on an accepted start and held internally for the whole run.
- h_idx  out  7  row index whose target distance is being read.
- h_val  in  7  target distance H[h_idx]; combinational read, valid in the same cycle.
- f_valid  out  1  F row available.
- f_ready  in  1  downstream accepts the row.
- f_row  out  128  filter row F[f_idx].
- f_idx  out  7  index of the presented row.
- busy  out  1  high from the accepted start until the DONE state.
- done  out  1  one-cycle pulse after row NROWS-1 is accepted.

Behaviour:
- Reset values: f_valid=0, f_row=0, f_idx=0, h_idx=0, busy=0, done=0, LFSR=LFSR_SEED, FSM=IDLE.
- FSM states: IDLE, LOAD, FLIP, OUT, DONE.
- IDLE
  - start=1 latches Pr into pr_q, sets row counter=0 and h_idx=0, reloads the LFSR with LFSR_SEED, asserts busy, and moves to LOAD.
  - start while not in IDLE is ignored.
- LOAD (1 cycle)
  - Captures tgt=h_val for h_idx, sets work=pr_q and flips=0.
  - tgt==0 goes directly to OUT; otherwise goes to FLIP.
- FLIP (one LFSR step per cycle)
  - pos = LFSR[6:0].
  - If work[pos]==pr_q[pos], the bit is unflipped: invert work[pos] and increment flips.
  - Otherwise the position was already flipped: skip the cycle, no change.
  - When flips+1==tgt on a flipping cycle, go to OUT.
  - The LFSR advances every FLIP cycle, including skips, and does not advance in any other state.
- OUT
  - f_valid=1, f_row=work, f_idx=row counter.
  - All three are held stable while f_ready=0.
  - On f_valid&&f_ready:
    - last row (row counter==NROWS-1): go to DONE.
    - otherwise: increment the row counter and h_idx, then go to LOAD.
  - f_valid drops in the cycle after acceptance.
- DONE (1 cycle): done=1, busy=0, then return to IDLE.
- Timing:
  - Latency per row = 1 (LOAD) + FLIP cycles (≥ tgt) + the OUT wait.
  - Row with tgt=0: f_valid rises 1 cycle after LOAD.
  - FLIP duration is unbounded only in theory; the maximal-length LFSR guarantees every 7-bit position appears within 2^LFSR_W cycles.
- Width rules: flips and tgt are 7 bits; the maximum target is 127, which is always reachable because 128 positions exist.
- Boundary cases:
  - Row counter wraps only through DONE; no run ever emits more than NROWS rows.
  - Pr changing mid-run has no effect.
  - rst_n low mid-run aborts immediately to the reset values; no done pulse is produced.
  - Because the LFSR is reseeded on every start, two runs with identical Pr and H give bit-identical F.

Optional Feature:
- Macro: FILTER_GEN_VERIFY_EN.
- Defined:
  - Adds output port verr (1 bit, reset 0).
  - In OUT, a combinational popcount of work^pr_q is compared with tgt on the accepting cycle.
  - On a mismatch, verr is set and stays sticky until the next accepted start or reset.
  - The popcount is a separate sub-module instance.
- Undefined: no port, no popcount logic, no effect on timing.

Decomposition:
- Package filter_gen_pkg:
  - state enum fsm_t {IDLE, LOAD, FLIP, OUT, DONE}.
  - constants KEY_W=128 and IDX_W=7.
  - LFSR default seed and taps.
- Sub-module popcount128: 128-bit input, 8-bit count, purely combinational.
  - Instantiated only under FILTER_GEN_VERIFY_EN.
  - Reusable by the verification bench as the reference model.

Test Plan:
- Reset/idle: hold rst_n=0 for 3 cycles, then release with start=0 for 10 cycles -> all outputs remain 0 and busy=0.
- All-zero targets: Pr=alternating 0101…, h_val=0 for all rows, f_ready=1 -> 128 rows each equal to Pr, f_idx=0..127 in order, each row 2 cycles apart, a single done pulse, busy low afterwards.
- Exact distance: h_val=(idx%2 ? 70 : 58), Pr random, f_ready=1 -> popcount(f_row^Pr) matches h_val for every row; row 0 has distance 58, row 1 has 70. Run again with identical Pr and H -> identical F.
- Back-pressure: f_ready=0 for 20 cycles on row 5 -> f_valid, f_row and f_idx stay constant, the LFSR does not advance, and the run resumes correctly after f_ready=1.
- Max target plus ignored start: h_val=127 on row 0, with a start pulse issued during FLIP -> exactly 127 bits flipped, the start is ignored, and the row index continues normally.
- Reset mid-run: deassert rst_n during row 40 FLIP, then restart -> outputs are cleared, no done pulse, the new run begins at f_idx=0, and F equals the first run's F. With FILTER_GEN_VERIFY_EN, verr stays 0 throughout.
